mdu_seq: RTL and testbench



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 35 +++
 rtl/mdu_seq.sv | 181 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the sequential multiply/divide unit: op encoding, FSM states, default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration, purely combinational. Multiply: conditional add then shift right on
// {carry, acc, mplr}. Divide: restoring trial subtract then shift left on {rem, quot}.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH:0]   part_i,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH:0]   part_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum    = {1'b0, part_i[2*WIDTH-1:WIDTH]} + (part_i[0] ? {1'b0, opnd} : '0);
        rem_sh = {part_i[2*WIDTH:WIDTH], part_i[WIDTH-1]};
        // rem_sh < 2*divisor, so the top bit of the difference is a clean borrow flag.
        diff   = rem_sh - {2'b00, opnd};
        part_o = '0;
        if (is_div) begin
            if (diff[WIDTH+1]) begin
                part_o = {rem_sh[WIDTH:0], part_i[WIDTH-2:0], 1'b0};
            end else begin
                part_o = {diff[WIDTH:0], part_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            part_o = {1'b0, sum, part_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide: done WIDTH+2 edges after the accepting edge; start is ignored while busy or
// while an accepted request is pending. MDU_DIV0_FLAG_EN adds div0 and a one-edge divide-by-zero path.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH + 1;

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [PW-1:0]    part_q, part_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MDU_DIV0_FLAG_EN
    logic             div0_q, div0_d;
`endif

    mdu_op_t            op_e;
    logic               accept, a_neg, b_neg;
    logic [PW-1:0]      step_part;
    logic [2*WIDTH-1:0] raw, prod;
    logic [WIDTH-1:0]   quo, rmd, fix_hi, fix_lo;

    assign op_e = mdu_op_t'(op);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .part_i (part_q),
        .is_div (is_div_q),
        .opnd   (is_div_q ? mag_b_q : mag_a_q),
        .part_o (step_part)
    );

    // Outside FIX the only consumer is the skipped divide by zero: all-ones quotient, remainder = dividend.
    always_comb begin
        raw    = (state_q == FIX) ? part_q[2*WIDTH-1:0] : {mag_a_q, {WIDTH{1'b1}}};
        prod   = neg_lo_q ? -raw : raw;
        quo    = neg_lo_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        rmd    = neg_hi_q ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        fix_hi = is_div_q ? rmd : prod[2*WIDTH-1:WIDTH];
        fix_lo = is_div_q ? quo : prod[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        part_d   = part_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MDU_DIV0_FLAG_EN
        div0_d   = 1'b0;
`endif
        a_neg  = op_is_signed(op_e) && a[WIDTH-1];
        b_neg  = op_is_signed(op_e) && b[WIDTH-1];
        accept = start && !req_q && ((state_q == IDLE) || (state_q == DONE));

        // The accepting edge only registers magnitudes; the datapath is loaded one edge later.
        case (state_q)
            IDLE: begin
                if (req_q) begin
                    req_d   = 1'b0;
                    state_d = RUN;
                    cnt_d   = '0;
                    part_d  = {{(WIDTH+1){1'b0}}, (is_div_q ? mag_a_q : mag_b_q)};
`ifdef MDU_DIV0_FLAG_EN
                    if (is_div_q && (mag_b_q == '0)) begin
                        state_d = DONE;
                        hi_d    = fix_hi;
                        lo_d    = fix_lo;
                        div0_d  = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                part_d = step_part;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            req_d    = 1'b1;
            is_div_d = op_is_div(op_e);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            mag_a_d  = a_neg ? -a : a;
            mag_b_d  = b_neg ? -b : b;
        end

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            part_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            part_q   <= part_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: hand-computed results, latency and busy-cycle counts per request.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int W        = MDU_WIDTH;
    localparam int FULL_LAT = W + 2;
`ifdef MDU_DIV0_FLAG_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = W + 2;
`endif

    logic         clk, reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
    logic         div0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .div0  (div0)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the unit idle or in its done cycle; returns #1 after the done edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input int e_lat, input logic e_div0, input int glitch);
        int lat   = 0;
        int nbusy = 0;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = MDU_DIV;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
            if (lat == glitch) begin
                start = 1'b1;
                op    = MDU_MULT;
                a     = 32'd3;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(e_lat - 1));
        chk({tag, ".hi"}, 64'(hi), 64'(e_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(e_lo));
`ifdef MDU_DIV0_FLAG_EN
        chk({tag, ".div0"}, 64'(div0), 64'(e_div0));
`else
        if (e_div0 !== 1'b0 && e_div0 !== 1'b1) chk({tag, ".div0_arg"}, 64'(e_div0), 64'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = MDU_MULTU;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.hi",   64'(hi),   64'd0);
        chk("reset.lo",   64'(lo),   64'd0);
`ifdef MDU_DIV0_FLAG_EN
        chk("reset.div0", 64'(div0), 64'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               FULL_LAT, 1'b0, -1);
        @(posedge clk);
        #1;
        chk("multu_max.done_drop", 64'(done), 64'd0);
        chk("multu_max.busy_idle", 64'(busy), 64'd0);
        chk("multu_max.hi_hold",   64'(hi),   64'hFFFF_FFFE);

        run_op("mult_m3x5",   MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
               FULL_LAT, 1'b0, -1);
        run_op("mult_minsq",  MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
               FULL_LAT, 1'b0, -1);
        run_op("div_m7d2",    MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               FULL_LAT, 1'b0, -1);
        run_op("div_min_m1",  MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
               FULL_LAT, 1'b0, -1);
        run_op("divu_100d7",  MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, FULL_LAT, 1'b0, -1);
        run_op("divu_100d0",  MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV0_LAT, 1'b1, -1);
        run_op("div_m5d0",    MDU_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001,
               DIV0_LAT, 1'b1, -1);
        run_op("div_9d0",     MDU_DIV,  32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, DIV0_LAT, 1'b1, -1);
        @(posedge clk);
        #1;

        // A start pulse in RUN cycle 5 must be dropped.
        run_op("ignore_start", MDU_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780,
               FULL_LAT, 1'b0, 5);
        // Start issued in the done cycle is accepted on the same edge that ends it.
        run_op("back2back", MDU_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, FULL_LAT, 1'b0, -1);
        @(posedge clk);
        #1;

        op    = MDU_MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("rst_mid.busy_before", 64'(busy), 64'd1);
        chk("rst_mid.lo_before",   64'(lo),   64'd100);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);
        chk("rst_mid.hi",   64'(hi),   64'd0);
        chk("rst_mid.lo",   64'(lo),   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op("after_rst", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, FULL_LAT, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
